uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte buffer and launch controller sitting directly upstream of the UART transmitter. It accepts bytes from the register/bus interface at bus speed and stores them in a synchronous FIFO. It feeds them one at a time to the transmitter through that block's transmit / tx_byte / is_transmitting handshake. It lets software queue a burst without polling the transmitter per byte.

Parameters:
DEPTH, 32, number of byte entries; power of two, minimum 2.
ADDR_WIDTH, 5, log2(DEPTH); pointer width.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
wr_stb  input  1  one-cycle strobe: push wr_data
wr_data  input  8  byte to queue
flush  input  1  one-cycle strobe: discard all queued bytes
clear_overflow  input  1  one-cycle strobe: clear sticky overflow flag
full  output  1  FIFO holds DEPTH bytes
empty  output  1  FIFO holds 0 bytes
count  output  ADDR_WIDTH+1  bytes currently queued, range 0..DEPTH
overflow  output  1  sticky: a write was dropped because FIFO was full
idle  output  1  empty and controller in S_IDLE and uart_is_transmitting low
uart_transmit  output  1  one-cycle launch pulse to transmitter
uart_tx_byte  output  8  byte presented to transmitter; held stable until next launch
uart_is_transmitting  input  1  transmitter busy indication

Behaviour:
- Reset (rst low, async assert, sync release) clears:
  - pointers, count=0, empty=1, full=0, overflow=0
  - uart_transmit=0, uart_tx_byte=8'h00, state=S_IDLE, idle=1
- All outputs are registered except full, empty and idle, which are decoded from registered count/state.
- Storage: DEPTH x 8 array, wr_ptr/rd_ptr of ADDR_WIDTH bits, natural wrap at DEPTH. count is tracked separately (ADDR_WIDTH+1 bits).
- Write: wr_stb with !full -> mem[wr_ptr]<=wr_data, wr_ptr+1, count+1.
- Write with full -> byte dropped, pointers/count unchanged, overflow<=1.
- Pop (internal, from FSM): uart_tx_byte<=mem[rd_ptr], rd_ptr+1, count-1.
- Write and pop in same cycle:
  - count unchanged, both pointers advance.
  - Permitted even when full, because the pop frees a slot in the same cycle; no overflow.
- flush: wr_ptr=rd_ptr=0, count=0 next cycle.
  - A coincident wr_stb is dropped and does not set overflow.
  - A coincident pop is cancelled.
  - A byte already launched finishes normally.
- overflow: set has priority over clear_overflow in the same cycle.
- Controller FSM:
  - S_IDLE: if !empty && !uart_is_transmitting && !flush -> pop, uart_transmit<=1, go S_WAIT_START.
  - S_WAIT_START: uart_transmit<=0; when uart_is_transmitting=1 -> S_WAIT_DONE.
  - S_WAIT_DONE: when uart_is_transmitting=0 -> S_IDLE.
  - Any unused encoding -> S_IDLE.
- Latency:
  - Byte written at cycle W into an empty FIFO with the transmitter idle: empty falls at W+1, and the pop/launch decision is made at W+1.
  - uart_transmit is high during W+2.
  - The transmitter raises uart_is_transmitting at W+3.
- Back-to-back: the next launch occurs no earlier than the cycle after uart_is_transmitting is seen low. Exactly one uart_transmit pulse is produced per popped byte.
- A transmitter reset mid-byte (is_transmitting drops early) returns the FSM to S_IDLE. No retry; the byte is considered consumed.

Decomposition:
- Shared package uart_pkg:
  - FSM state localparams (S_IDLE=0, S_WAIT_START=1, S_WAIT_DONE=2)
  - UART_BYTE_WIDTH=8
  - PRESCALER_COUNT=16
- One sub-module, uart_byte_fifo: storage, pointers, count, full/empty, overflow and flush.
- uart_tx_fifo instantiates it and adds the launch FSM.

Test Plan:
- Reset then write 8'hA5 with uart_is_transmitting=0 -> uart_transmit pulses exactly one cycle at W+2 with uart_tx_byte=8'hA5; empty=1 and count=0 afterwards.
- Write 32 bytes 0x00..0x1F while the transmitter model holds busy, then 33rd byte 0x55 -> full=1, count=32, overflow=1; bytes emerge 0x00..0x1F in order, 0x55 never appears.
- Write while full in the same cycle as a pop (busy deasserts) -> count stays 32, overflow stays 0, written byte later transmitted.
- Queue 4 bytes, assert flush together with wr_stb of 0x77 while the first byte is in S_WAIT_DONE -> in-flight byte completes, count=0 next cycle, no further uart_transmit, 0x77 never sent, overflow=0.
- overflow set, then clear_overflow coincident with another full-write -> overflow remains 1; clear_overflow alone next cycle -> overflow=0.
- Assert rst low asynchronously mid-byte with count=5 -> all outputs return to reset values immediately (uart_transmit=0, count=0, idle=1) without waiting for clk.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encodings, byte width and the prescaler constant.
// Imported by the transmit FIFO and its launch controller.
package uart_pkg;

  localparam int UART_BYTE_WIDTH = 8;
  localparam int PRESCALER_COUNT = 16;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_START = 2'd1;
  localparam logic [1:0] S_WAIT_DONE  = 2'd2;

  typedef logic [UART_BYTE_WIDTH-1:0] byte_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with separate count, sticky overflow and flush; pushed data is poppable the next cycle.
// No backpressure: a write while full is dropped (unless a pop frees the slot that same cycle) and flags overflow.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_stb,
  input  byte_t               wr_data,
  input  logic                pop,
  input  logic                flush,
  input  logic                clear_overflow,
  output byte_t               head,
  output logic                full,
  output logic                empty,
  output logic [ADDR_WIDTH:0] count,
  output logic                overflow
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  byte_t                 mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_pop;
  logic                  ovf_set;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
  assign do_pop  = pop && !empty && !flush;
  assign do_wr   = wr_stb && !flush && (!full || do_pop);
  assign ovf_set = wr_stb && !flush && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_wr, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Queues bus-written bytes and launches them one at a time into the UART transmitter.
// Launch pulse two cycles after a write into an idle path; waits for is_transmitting to rise and fall between bytes.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_stb,
  input  logic [UART_BYTE_WIDTH-1:0] wr_data,
  input  logic                       flush,
  input  logic                       clear_overflow,
  output logic                       full,
  output logic                       empty,
  output logic [ADDR_WIDTH:0]        count,
  output logic                       overflow,
  output logic                       idle,
  output logic                       uart_transmit,
  output logic [UART_BYTE_WIDTH-1:0] uart_tx_byte,
  input  logic                       uart_is_transmitting
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       launch;
  byte_t      head;

  uart_byte_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .wr_stb         (wr_stb),
    .wr_data        (wr_data),
    .pop            (launch),
    .flush          (flush),
    .clear_overflow (clear_overflow),
    .head           (head),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A transmitter that drops busy early (its own reset) simply ends the byte; no retry.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:       state_nxt = launch ? S_WAIT_START : S_IDLE;
      S_WAIT_START: state_nxt = uart_is_transmitting ? S_WAIT_DONE : S_WAIT_START;
      S_WAIT_DONE:  state_nxt = uart_is_transmitting ? S_WAIT_DONE : S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    launch = (state == S_IDLE) && !empty && !uart_is_transmitting && !flush;
    idle   = empty && (state == S_IDLE) && !uart_is_transmitting;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_transmit <= 1'b0;
      uart_tx_byte  <= '0;
    end else begin
      uart_transmit <= launch;
      if (launch) begin
        uart_tx_byte <= head;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a simple transmitter model.
// Expected launches are queued at write time and matched by a negedge monitor.
module tb_uart_tx_fifo;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_stb = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        flush = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        full, empty, overflow, idle, uart_transmit;
  logic [AW:0] count;
  logic [7:0]  uart_tx_byte;
  logic        ext_busy = 1'b0;
  logic        model_busy = 1'b0;
  logic        uart_is_transmitting;

  // The transmitter shares the reset, so its busy flag clears with it.
  assign uart_is_transmitting = rst & (ext_busy | model_busy);

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   launches = 0;
  int   tx_len = 4;
  bit   prev_tx = 1'b0;
  exp_t exp_q[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wr_stb               (wr_stb),
    .wr_data              (wr_data),
    .flush                (flush),
    .clear_overflow       (clear_overflow),
    .full                 (full),
    .empty                (empty),
    .count                (count),
    .overflow             (overflow),
    .idle                 (idle),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit sent, input bit timed);
    exp_t e;
    wr_stb  = 1'b1;
    wr_data = d;
    if (sent) begin
      e.data = d;
      e.cyc  = timed ? cyc + 2 : -1;
      exp_q.push_back(e);
    end
    tick(1);
    wr_stb = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(idle && exp_q.size() == 0) && n < max) begin
      tick(1);
      n++;
    end
    if (n >= max) fail("idle_timeout");
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!uart_is_transmitting && n < 50) begin
      tick(1);
      n++;
    end
    if (!uart_is_transmitting) fail("busy_timeout");
  endtask

  // Transmitter model: busy one cycle after the launch pulse, for tx_len cycles.
  always begin
    @(negedge clk);
    if (rst && uart_transmit) begin
      launches++;
      @(posedge clk);
      #1 model_busy = 1'b1;
      for (int i = 0; i < tx_len; i++) begin
        @(posedge clk or negedge rst);
        if (!rst) break;
      end
      #1 model_busy = 1'b0;
    end
  end

  // Monitor: every launch pulse must match the head of the expected queue.
  always begin
    exp_t e;
    @(negedge clk);
    if (rst && uart_transmit) begin
      check("tx_pulse_single", int'(prev_tx), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch: got byte 0x%0h expected none (cycle %0d)", uart_tx_byte, cyc);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", uart_tx_byte, e.data);
        if (e.cyc >= 0) check("launch_cycle", cyc, e.cyc);
      end
    end
    prev_tx = rst & uart_transmit;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;

    // Reset values, both during and after reset
    tick(3);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_transmit", uart_transmit, 0);
    check("rst_tx_byte", uart_tx_byte, 8'h00);
    check("rst_idle", idle, 1);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    check("post_rst_idle", idle, 1);

    // Single byte: launch at W+2, FIFO drains
    push_byte(8'hA5, 1, 1);
    check("w1_empty", empty, 0);
    check("w1_count", count, 1);
    wait_idle(100);
    check("w1_drained_count", count, 0);
    check("w1_drained_empty", empty, 1);

    // Fill while transmitter busy, then overflow
    ext_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1, 0);
    check("fill_full", full, 1);
    check("fill_count", count, 32);
    check("fill_overflow", overflow, 0);
    push_byte(8'h55, 0, 0);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 32);
    check("ovf_full", full, 1);

    // Overflow set beats clear; clear alone works
    clear_overflow = 1'b1;
    push_byte(8'h66, 0, 0);
    clear_overflow = 1'b0;
    check("ovf_set_beats_clear", overflow, 1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("ovf_clear", overflow, 0);

    // Write while full coincident with a pop
    ext_busy = 1'b0;
    push_byte(8'hC3, 1, 0);
    check("wpop_count", count, 32);
    check("wpop_overflow", overflow, 0);
    check("wpop_full", full, 1);
    wait_idle(2000);
    check("drain_count", count, 0);

    // Flush with coincident write while first byte is in flight
    tx_len = 12;
    push_byte(8'h11, 1, 1);
    push_byte(8'h22, 0, 0);
    push_byte(8'h33, 0, 0);
    push_byte(8'h44, 0, 0);
    wait_busy();
    tick(2);
    l0 = launches;
    flush = 1'b1;
    push_byte(8'h77, 0, 0);
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_overflow", overflow, 0);
    check("flush_inflight_busy", uart_is_transmitting, 1);
    wait_idle(200);
    check("flush_no_more_launches", launches, l0);

    // Asynchronous reset mid-byte with 5 queued
    push_byte(8'h60, 1, 1);
    for (int i = 1; i < 6; i++) push_byte(8'(8'h60 + i), 1, 0);
    wait_busy();
    tick(2);
    check("prerst_count", count, 5);
    check("prerst_tx_byte", uart_tx_byte, 8'h60);
    #1 rst = 1'b0;
    exp_q.delete();
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_transmit", uart_transmit, 0);
    check("arst_tx_byte", uart_tx_byte, 8'h00);
    check("arst_idle", idle, 1);
    @(negedge clk);
    rst = 1'b1;
    tick(1);

    // Normal operation resumes after reset
    tx_len = 4;
    push_byte(8'h5A, 1, 1);
    wait_idle(100);
    check("queue_drained", exp_q.size(), 0);
    check("final_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
